// File: rtl/sync_debounce_edge.sv
// Resynchronises and debounces one async input into a clean level plus rise/fall pulses.
// Define EDGE_CNT_EN to build the rising-edge counter; otherwise edge_cnt is tied to 0.
module sync_debounce_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int DB_W        = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam logic [1:0] ST_LO     = 2'd0;
    localparam logic [1:0] ST_CHK_HI = 2'd1;
    localparam logic [1:0] ST_HI     = 2'd2;
    localparam logic [1:0] ST_CHK_LO = 2'd3;

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);
    localparam bit              SINGLE   = (DB_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    // din enters the design only through this chain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        s      = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (s) begin
                    if (SINGLE) begin
                        state_d = ST_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_CHK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CHK_HI: begin
                if (!s) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!s) begin
                    if (SINGLE) begin
                        state_d = ST_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_CHK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CHK_LO: begin
                if (s) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= ST_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef EDGE_CNT_EN
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

    // counts in step with the registered rise pulse; wraps naturally
    always_comb begin
        edge_cnt_d = edge_cnt_q + {{(CNT_W-1){1'b0}}, rise_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`else
    assign edge_cnt = '0;
`endif

endmodule
